tlp_flow_fsm: RTL and testbench

Main flow-control state machine of the TLP PCIe datapath. Monitors the status flags of four transaction FIFOs (empty, almost-full pause, almost-empty continue, error, full) and drives the aggregated control outputs: per-FIFO pause/continue requests, per-FIFO error/full reporting, and a global idle indication. Sits beside the FIFO bank and feeds the arbiter/upstream logic that throttles writes.

---
 rtl/tlp_flow_fsm_pkg.sv | 14 +
 rtl/tlp_flow_fsm.sv | 106 ++++++++++
 tb/tb_tlp_flow_fsm.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/tlp_flow_fsm_pkg.sv
// Shared constants for the TLP flow-control state machine: state encodings
// and the fixed number of monitored FIFOs.
package tlp_flow_fsm_pkg;

  localparam int unsigned FIFO_N = 4;

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_PAUSE  = 3'd4;
  localparam logic [2:0] ST_ERROR  = 3'd5;

endpackage

// File: rtl/tlp_flow_fsm.sv
// Main flow-control FSM of the TLP datapath. Watches the status flags of the
// four transaction FIFOs and produces registered per-FIFO pause/continue
// requests, sticky error/full reports and a global idle indication.
// The resume output is named continue_req because "continue" is a reserved word.
module tlp_flow_fsm
  import tlp_flow_fsm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              FIFOpause0,
  input  logic              FIFOpause1,
  input  logic              FIFOpause2,
  input  logic              FIFOpause3,
  input  logic              FIFOcontinue0,
  input  logic              FIFOcontinue1,
  input  logic              FIFOcontinue2,
  input  logic              FIFOcontinue3,
  input  logic              FIFOempty0,
  input  logic              FIFOempty1,
  input  logic              FIFOempty2,
  input  logic              FIFOempty3,
  input  logic              FIFOerror0,
  input  logic              FIFOerror1,
  input  logic              FIFOerror2,
  input  logic              FIFOerror3,
  input  logic              FIFOfull0,
  input  logic              FIFOfull1,
  input  logic              FIFOfull2,
  input  logic              FIFOfull3,
  output logic [FIFO_N-1:0] error_full,
  output logic [FIFO_N-1:0] pause,
  output logic [FIFO_N-1:0] continue_req,
  output logic              idle
);

  logic [FIFO_N-1:0] pause_in;
  logic [FIFO_N-1:0] cont_in;
  logic [FIFO_N-1:0] empty_in;
  logic [FIFO_N-1:0] errfull_in;

  logic [2:0] state;
  logic [2:0] state_next;
  logic       err;
  logic       any_pause;
  logic       all_empty;
  logic       flowing;

  assign pause_in   = {FIFOpause3, FIFOpause2, FIFOpause1, FIFOpause0};
  assign cont_in    = {FIFOcontinue3, FIFOcontinue2, FIFOcontinue1, FIFOcontinue0};
  assign empty_in   = {FIFOempty3, FIFOempty2, FIFOempty1, FIFOempty0};
  assign errfull_in = {FIFOerror3 | FIFOfull3, FIFOerror2 | FIFOfull2,
                       FIFOerror1 | FIFOfull1, FIFOerror0 | FIFOfull0};

  assign err       = |errfull_in;
  assign any_pause = |pause_in;
  assign all_empty = &empty_in;
  assign flowing   = (state_next == ST_ACTIVE) || (state_next == ST_PAUSE);

  // Next-state selection with priority error > init > pause > all-empty
  always_comb begin
    state_next = state;
    case (state)
      ST_RESET: state_next = ST_INIT;
      ST_INIT: begin
        if (err)       state_next = ST_ERROR;
        else if (init) state_next = ST_INIT;
        else           state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (err)             state_next = ST_ERROR;
        else if (init)       state_next = ST_INIT;
        else if (!all_empty) state_next = any_pause ? ST_PAUSE : ST_ACTIVE;
        else                 state_next = ST_IDLE;
      end
      ST_ACTIVE, ST_PAUSE: begin
        if (err)            state_next = ST_ERROR;
        else if (init)      state_next = ST_INIT;
        else if (any_pause) state_next = ST_PAUSE;
        else if (all_empty) state_next = ST_IDLE;
        else                state_next = ST_ACTIVE;
      end
      ST_ERROR: state_next = ST_ERROR;
      default:  state_next = ST_RESET;
    endcase
  end

  // State register and outputs, all derived from the upcoming state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_RESET;
      error_full   <= '0;
      pause        <= '0;
      continue_req <= '0;
      idle         <= 1'b0;
    end else begin
      state        <= state_next;
      idle         <= (state_next == ST_IDLE);
      pause        <= flowing ? pause_in : '0;
      continue_req <= flowing ? (cont_in & ~pause_in) : '0;
      if (state != ST_RESET)
        error_full <= error_full | errfull_in;
    end
  end

endmodule

// File: tb/tb_tlp_flow_fsm.sv
// Self-checking bench for tlp_flow_fsm: directed sequence followed by
// randomized FIFO flag traffic, compared against a behavioural model.
module tb_tlp_flow_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init = 1'b0;
  logic [3:0] p = '0;
  logic [3:0] c = '0;
  logic [3:0] e = '1;
  logic [3:0] er = '0;
  logic [3:0] f = '0;

  logic [3:0] error_full;
  logic [3:0] pause;
  logic [3:0] continue_req;
  logic       idle;

  always #5 clk = ~clk;

  tlp_flow_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .FIFOpause0   (p[0]),
    .FIFOpause1   (p[1]),
    .FIFOpause2   (p[2]),
    .FIFOpause3   (p[3]),
    .FIFOcontinue0(c[0]),
    .FIFOcontinue1(c[1]),
    .FIFOcontinue2(c[2]),
    .FIFOcontinue3(c[3]),
    .FIFOempty0   (e[0]),
    .FIFOempty1   (e[1]),
    .FIFOempty2   (e[2]),
    .FIFOempty3   (e[3]),
    .FIFOerror0   (er[0]),
    .FIFOerror1   (er[1]),
    .FIFOerror2   (er[2]),
    .FIFOerror3   (er[3]),
    .FIFOfull0    (f[0]),
    .FIFOfull1    (f[1]),
    .FIFOfull2    (f[2]),
    .FIFOfull3    (f[3]),
    .error_full   (error_full),
    .pause        (pause),
    .continue_req (continue_req),
    .idle         (idle)
  );

  // Behavioural reference model
  typedef enum {M_RST, M_INIT, M_IDLE, M_ACT, M_PAUSE, M_ERR} mst_t;
  mst_t       ms = M_RST;
  logic [3:0] m_ef = '0;
  logic [3:0] m_p = '0;
  logic [3:0] m_c = '0;
  logic       m_idle = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic mst_t model_next(input mst_t s);
    bit any_err, any_p, all_e;
    any_err = ((er | f) != 4'b0000);
    any_p   = (p != 4'b0000);
    all_e   = (e == 4'b1111);
    if (s == M_RST) return M_INIT;
    if (s == M_ERR) return M_ERR;
    if (any_err)    return M_ERR;
    if (init)       return M_INIT;
    if (s == M_INIT) return M_IDLE;
    if (s == M_IDLE) return all_e ? M_IDLE : (any_p ? M_PAUSE : M_ACT);
    if (any_p)      return M_PAUSE;
    if (all_e)      return M_IDLE;
    return M_ACT;
  endfunction

  task automatic model_step();
    mst_t nx;
    bit   flow;
    nx     = model_next(ms);
    flow   = (nx == M_ACT) || (nx == M_PAUSE);
    m_idle = (nx == M_IDLE);
    m_p    = flow ? p : 4'b0000;
    m_c    = flow ? (c & ~p) : 4'b0000;
    if (ms != M_RST) m_ef = m_ef | er | f;
    ms = nx;
  endtask

  task automatic model_reset();
    ms = M_RST; m_ef = '0; m_p = '0; m_c = '0; m_idle = 1'b0;
  endtask

  task automatic compare();
    chk("error_full", error_full, m_ef);
    chk("pause", pause, m_p);
    chk("continue", continue_req, m_c);
    chk("idle", {3'b000, idle}, {3'b000, m_idle});
  endtask

  // One clock: model samples the same inputs as the DUT, outputs checked after the edge
  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    else model_reset();
    #1 compare();
  endtask

  // Asynchronous reset pulse placed mid-cycle, released before the next edge
  task automatic reset_pulse();
    #2 reset = 1'b0;
    model_reset();
    #1 compare();
    #2 reset = 1'b1;
  endtask

  initial begin
    #2 reset = 1'b0;
    repeat (3) tick();

    reset = 1'b1; init = 1'b1;
    tick();
    tick();
    init = 1'b0;
    tick();
    chk("idle_after_init", {3'b000, idle}, 4'b0001);

    e = 4'b0000;
    tick();
    chk("active_pause", pause, 4'b0000);

    p = 4'b1111;
    tick();
    chk("pause_all", pause, 4'b1111);
    chk("pause_all_cont", continue_req, 4'b0000);

    p = 4'b0000; c = 4'b1111;
    tick();
    chk("resume_cont", continue_req, 4'b1111);

    p = 4'b0101; c = 4'b1010;
    tick();
    chk("mixed_pause", pause, 4'b0101);
    chk("mixed_cont", continue_req, 4'b1010);

    er = 4'b0001;
    tick();
    chk("err_sticky", error_full, 4'b0001);
    er = 4'b0000; init = 1'b1;
    tick();
    init = 1'b0;
    tick();
    chk("err_absorb", error_full, 4'b0001);
    chk("err_idle", {3'b000, idle}, 4'b0000);

    reset_pulse();
    chk("async_clear", error_full, 4'b0000);
    p = 4'b0000; c = 4'b0000; f = 4'b1000;
    tick();
    tick();
    chk("full3_sticky", error_full, 4'b1000);
    f = 4'b0000;

    reset_pulse();
    for (int i = 0; i < 600; i++) begin
      p    = 4'($urandom);
      c    = 4'($urandom);
      e    = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom);
      er   = ($urandom_range(0, 50) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      f    = ($urandom_range(0, 50) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      init = ($urandom_range(0, 12) == 0);
      if ((ms == M_ERR && $urandom_range(0, 5) == 0) || $urandom_range(0, 80) == 0)
        reset_pulse();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
